// File: rtl/fpu_round_arbiter.sv
// Round-robin arbiter that time-shares one normalize/round/post-normalize datapath
// between NREQ FPU producers and returns a tagged completion with backpressure.
package fpu_round_arbiter_pkg;
    localparam int unsigned FR_W = 57;
    localparam int unsigned ER_W = 13;

    typedef struct packed {
        logic [FR_W-1:0] fr;
        logic [ER_W-1:0] er;
        logic            db;
        logic            ovfen;
        logic            unfen;
    } rnd_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_ROUND,
        S_ADJUST,
        S_DONE
    } state_t;
endpackage

module fpu_round_arbiter
    import fpu_round_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned TAGW      = 2,
    parameter int unsigned SHIFT_LAT = 2,
    parameter int unsigned RND_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FR_W-1:0] req_fr,
    input  logic [NREQ*ER_W-1:0] req_er,
    input  logic [NREQ-1:0]      req_db,
    input  logic [NREQ-1:0]      req_ovfen,
    input  logic [NREQ-1:0]      req_unfen,
    output logic [FR_W-1:0]      dp_fr,
    output logic [ER_W-1:0]      dp_er,
    output logic                 dp_db,
    output logic                 dp_ovfen,
    output logic                 dp_unfen,
    output logic                 dp_start,
    input  logic                 dp_sigovf,
    output logic                 dp_postnorm,
    output logic                 res_valid,
    output logic [TAGW-1:0]      res_tag,
    input  logic                 res_ready,
    output logic                 busy
);

    localparam int unsigned MAX_LAT = (SHIFT_LAT > RND_LAT) ? SHIFT_LAT : RND_LAT;
    localparam int unsigned CNTW    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int unsigned PW      = TAGW + 1;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [TAGW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAGW-1:0] tag_q, tag_d;
    rnd_op_t         op_q, op_d;
    logic            start_q, start_d;
    logic            postnorm_q, postnorm_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;

    rnd_op_t         slot_op [NREQ];
    logic [TAGW-1:0] win_idx;
    logic            win_found;
    logic [PW-1:0]   cand;
    logic            handshake;

    // Unpack each requester's operand slot from the flat buses.
    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot_op[i].fr    = req_fr[i*FR_W +: FR_W];
        assign slot_op[i].er    = req_er[i*ER_W +: ER_W];
        assign slot_op[i].db    = req_db[i];
        assign slot_op[i].ovfen = req_ovfen[i];
        assign slot_op[i].unfen = req_unfen[i];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'(rr_ptr_q) + PW'(k);
            if (cand >= PW'(NREQ)) begin
                cand = cand - PW'(NREQ);
            end
            if (!win_found && (|(req_valid & (NREQ'(1) << cand)))) begin
                win_found = 1'b1;
                win_idx   = cand[TAGW-1:0];
            end
        end
    end

    assign handshake = (state_q == S_IDLE) && win_found && !rst;
    assign req_ready = handshake ? (NREQ'(1) << win_idx) : '0;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        tag_d       = tag_q;
        op_d        = op_q;
        start_d     = 1'b0;
        postnorm_d  = 1'b0;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    state_d  = S_SHIFT;
                    cnt_d    = CNTW'(SHIFT_LAT - 1);
                    op_d     = slot_op[win_idx];
                    tag_d    = win_idx;
                    rr_ptr_d = (win_idx == TAGW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    start_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = S_ROUND;
                    cnt_d   = CNTW'(RND_LAT - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ROUND: begin
                if (cnt_q == '0) begin
                    state_d = dp_sigovf ? S_ADJUST : S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ADJUST: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        postnorm_d  = (state_d == S_ADJUST);
        res_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            tag_q       <= '0;
            op_q        <= '0;
            start_q     <= 1'b0;
            postnorm_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_q       <= tag_d;
            op_q        <= op_d;
            start_q     <= start_d;
            postnorm_q  <= postnorm_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign dp_fr       = op_q.fr;
    assign dp_er       = op_q.er;
    assign dp_db       = op_q.db;
    assign dp_ovfen    = op_q.ovfen;
    assign dp_unfen    = op_q.unfen;
    assign dp_start    = start_q;
    assign dp_postnorm = postnorm_q;
    assign res_valid   = res_valid_q;
    assign res_tag     = tag_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fpu_round_arbiter.sv
// Directed bench for fpu_round_arbiter: latency, ADJUST path, round-robin order,
// result backpressure, mid-job reset and requests raised while busy.
module tb_fpu_round_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned TAGW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*57-1:0] req_fr;
    logic [NREQ*13-1:0] req_er;
    logic [NREQ-1:0]    req_db;
    logic [NREQ-1:0]    req_ovfen;
    logic [NREQ-1:0]    req_unfen;
    logic [56:0]        dp_fr;
    logic [12:0]        dp_er;
    logic               dp_db;
    logic               dp_ovfen;
    logic               dp_unfen;
    logic               dp_start;
    logic               dp_sigovf;
    logic               dp_postnorm;
    logic               res_valid;
    logic [TAGW-1:0]    res_tag;
    logic               res_ready;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [56:0] fr_tab [3];

    fpu_round_arbiter #(
        .NREQ(NREQ), .TAGW(TAGW), .SHIFT_LAT(2), .RND_LAT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fr(req_fr), .req_er(req_er), .req_db(req_db),
        .req_ovfen(req_ovfen), .req_unfen(req_unfen),
        .dp_fr(dp_fr), .dp_er(dp_er), .dp_db(dp_db),
        .dp_ovfen(dp_ovfen), .dp_unfen(dp_unfen),
        .dp_start(dp_start), .dp_sigovf(dp_sigovf), .dp_postnorm(dp_postnorm),
        .res_valid(res_valid), .res_tag(res_tag), .res_ready(res_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_fr"}, 64'(dp_fr), 64'(0));
        check_eq({tag, "_ctl"}, 64'({dp_er, dp_db, dp_ovfen, dp_unfen, dp_start, dp_postnorm,
                                    res_valid, res_tag, busy, req_ready}), 64'(0));
    endtask

    task automatic set_slot(input int i, input logic [56:0] fr, input logic [12:0] er,
                            input logic db, input logic ovf, input logic unf);
        req_fr[57*i +: 57] = fr;
        req_er[13*i +: 13] = er;
        req_db[i]          = db;
        req_ovfen[i]       = ovf;
        req_unfen[i]       = unf;
    endtask

    // Waits (bounded) for a nonzero req_ready and reports how many cycles that took.
    task automatic wait_grant(input logic [2:0] exp, output int gap);
        gap = 0;
        while (req_ready == 3'b000 && gap < 20) begin
            @(negedge clk); #1;
            gap++;
        end
        check_eq("grant", 64'(req_ready), 64'(exp));
    endtask

    task automatic do_job(input int idx, input int lat, input logic rdy,
                          input logic [2:0] nxt, input int gap_exp);
        int gap;
        int cyc;
        wait_grant(3'(1 << idx), gap);
        check_eq("job_gap", 64'(gap), 64'(gap_exp));
        res_ready = rdy;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                req_valid = nxt;
                check_eq("job_start", 64'(dp_start), 64'(1));
                check_eq("job_tag", 64'(res_tag), 64'(idx));
                check_eq("job_fr", 64'(dp_fr), 64'(fr_tab[idx]));
            end
            check_eq("job_ready_busy", 64'(req_ready), 64'(0));
        end while (!res_valid && cyc < 16);
        check_eq("job_valid", 64'(res_valid), 64'(1));
        check_eq("job_lat", 64'(cyc), 64'(lat));
        check_eq("job_tag_done", 64'(res_tag), 64'(idx));
    endtask

    initial begin
        int gap;
        fr_tab[0] = 57'h0FEDCBA98765432;
        fr_tab[1] = 57'h1F0F0F0F0F0F0F0;
        fr_tab[2] = 57'h0000000000000A5;

        rst = 1'b1; req_valid = '0; req_fr = '0; req_er = '0; req_db = '0;
        req_ovfen = '0; req_unfen = '0; dp_sigovf = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single request from slot 1, no overflow; sigovf toggled in SHIFT must be ignored.
        set_slot(1, 57'h123456789ABCDEF, 13'h0AAA, 1'b1, 1'b1, 1'b0);
        req_valid = 3'b010; dp_sigovf = 1'b1;
        #1;
        check_eq("s1_ready", 64'(req_ready), 64'(3'b010));
        check_eq("s1_idle_busy", 64'(busy), 64'(0));
        @(negedge clk); #1;
        req_valid = '0;
        check_eq("s1_fr", 64'(dp_fr), 64'(57'h123456789ABCDEF));
        check_eq("s1_ctl", 64'({dp_er, dp_db, dp_ovfen, dp_unfen}), 64'({13'h0AAA, 3'b110}));
        check_eq("s1_start", 64'(dp_start), 64'(1));
        check_eq("s1_busy1", 64'(busy), 64'(1));
        check_eq("s1_tag1", 64'(res_tag), 64'(1));
        @(negedge clk); #1;
        check_eq("s1_start_pulse", 64'(dp_start), 64'(0));
        check_eq("s1_busy2", 64'(busy), 64'(1));
        @(negedge clk); #1;
        dp_sigovf = 1'b0;
        check_eq("s1_round_valid", 64'(res_valid), 64'(0));
        @(negedge clk); #1;
        dp_sigovf = 1'b1;
        check_eq("s1_valid", 64'(res_valid), 64'(1));
        check_eq("s1_tag", 64'(res_tag), 64'(1));
        check_eq("s1_postnorm", 64'(dp_postnorm), 64'(0));
        check_eq("s1_busy4", 64'(busy), 64'(1));
        res_ready = 1'b1;
        @(negedge clk); #1;
        check_eq("s1_idle_valid", 64'(res_valid), 64'(0));
        check_eq("s1_idle_busy2", 64'(busy), 64'(0));
        check_eq("s1_fr_hold", 64'(dp_fr), 64'(57'h123456789ABCDEF));

        // Same job with carry-out on the ROUND cycle: one ADJUST cycle, latency 5.
        req_valid = 3'b010; dp_sigovf = 1'b0;
        #1;
        check_eq("s2_ready", 64'(req_ready), 64'(3'b010));
        @(negedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        dp_sigovf = 1'b1;
        check_eq("s2_round_pn", 64'(dp_postnorm), 64'(0));
        @(negedge clk); #1;
        dp_sigovf = 1'b0;
        check_eq("s2_postnorm", 64'(dp_postnorm), 64'(1));
        check_eq("s2_adj_valid", 64'(res_valid), 64'(0));
        @(negedge clk); #1;
        check_eq("s2_valid", 64'(res_valid), 64'(1));
        check_eq("s2_postnorm_off", 64'(dp_postnorm), 64'(0));
        check_eq("s2_tag", 64'(res_tag), 64'(1));
        @(negedge clk); #1;
        check_eq("s2_idle_busy", 64'(busy), 64'(0));
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;

        // All three requesting: grants 0,1,2 then wrap to 0.
        for (int i = 0; i < 3; i++) set_slot(i, fr_tab[i], 13'(i), 1'b0, 1'b0, 1'b1);
        req_valid = 3'b111; res_ready = 1'b1;
        #1;
        do_job(0, 4, 1'b1, 3'b111, 0);
        do_job(1, 4, 1'b1, 3'b111, 1);
        do_job(2, 4, 1'b1, 3'b111, 1);
        do_job(0, 4, 1'b1, 3'b111, 1);

        // Backpressure: DONE held six cycles with everything stable and no grant.
        do_job(1, 4, 1'b0, 3'b111, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check_eq("s4_valid", 64'(res_valid), 64'(1));
            check_eq("s4_tag", 64'(res_tag), 64'(1));
            check_eq("s4_fr", 64'(dp_fr), 64'(fr_tab[1]));
            check_eq("s4_ready", 64'(req_ready), 64'(0));
        end
        res_ready = 1'b1; req_valid = 3'b011;
        wait_grant(3'b001, gap);
        check_eq("s4_gap", 64'(gap), 64'(1));

        // Reset during SHIFT abandons the job and clears the round-robin pointer.
        @(negedge clk); #1;
        check_eq("s5_busy", 64'(busy), 64'(1));
        check_eq("s5_tag", 64'(res_tag), 64'(0));
        rst = 1'b1;
        @(negedge clk); #1;
        check_all_zero("s5_reset");
        rst = 1'b0;
        #1;
        check_eq("s5_rrptr", 64'(req_ready), 64'(3'b001));
        do_job(0, 4, 1'b1, 3'b100, 0);

        // Requester 0 raised while requester 2 is in flight waits for the next IDLE.
        do_job(2, 4, 1'b1, 3'b001, 1);
        do_job(0, 4, 1'b1, 3'b000, 1);
        @(negedge clk); #1;
        check_eq("s6_idle_busy", 64'(busy), 64'(0));
        check_eq("s6_idle_valid", 64'(res_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
